// File: rtl/lcd_bus_pkg.sv
// Shared types and timing defaults for the HD44780-style LCD bus sequencer.
// The command predicate decides which writes need the long execution wait.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_t;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_T_AS   = 2;
    localparam int DEF_T_PW   = 12;
    localparam int DEF_T_H    = 2;
    localparam int DEF_T_CMD  = 2000;
    localparam int DEF_T_LONG = 82000;
    localparam int DEF_CW     = 17;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear (0x01) and home (0x02/0x03) are the only commands with data[7:2] == 0,
    // and both need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data | LCD_CMD_CLEAR | LCD_CMD_HOME) == (LCD_CMD_CLEAR | LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_prio_arbiter.sv
// Fixed-priority arbiter: the lowest set request index receives a one-hot grant.
// This block is purely combinational.
module lcd_prio_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Serialises byte writes from prioritised requesters onto an HD44780-style LCD bus,
// generating the E-strobe setup/pulse/hold timing and the post-command execution wait.
module lcd_bus_sequencer
    import lcd_bus_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int T_AS   = DEF_T_AS,
    parameter int T_PW   = DEF_T_PW,
    parameter int T_H    = DEF_T_H,
    parameter int T_CMD  = DEF_T_CMD,
    parameter int T_LONG = DEF_T_LONG,
    parameter int CW     = DEF_CW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_rs,
    input  logic [NREQ-1:0][7:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_data_out,
    output logic                 lcd_data_oe,
    output logic                 busy
);

    localparam logic [CW-1:0] LD_AS   = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_PW   = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_H    = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_CMD  = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_LONG = CW'(T_LONG - 1);

    lcd_state_t      state;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] grant;
    logic            sel_rs;
    logic [7:0]      sel_data;
    logic            accept;
    logic            cnt_done;

    lcd_prio_arbiter #(
        .NREQ (NREQ)
    ) u_arbiter (
        .req   (req_valid),
        .grant (grant)
    );

    always_comb begin
        sel_rs   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rs   = req_rs[i];
                sel_data = req_data[i];
            end
        end
    end

    // Ready is the only combinational output: it must coincide with the cycle the
    // byte is latched, and it is forced low while reset is held.
    assign accept    = (state == IDLE) && (|grant);
    assign req_ready = (reset_n && state == IDLE) ? grant : '0;
    assign lcd_rw    = 1'b0;
    assign cnt_done  = (cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lcd_e        <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_data_out <= '0;
            lcd_data_oe  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lcd_e       <= 1'b0;
                    lcd_data_oe <= 1'b0;
                    if (accept) begin
                        lcd_rs       <= sel_rs;
                        lcd_data_out <= sel_data;
                        lcd_data_oe  <= 1'b1;
                        busy         <= 1'b1;
                        cnt          <= LD_AS;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b1;
                        cnt   <= LD_PW;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b0;
                        cnt   <= LD_H;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        lcd_data_oe <= 1'b0;
                        cnt         <= is_long_cmd(lcd_rs, lcd_data_out) ? LD_LONG : LD_CMD;
                        state       <= WAIT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and bus invariants that must hold regardless of requester behaviour.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
    a_ready_idle:   assert property (@(posedge clk) disable iff (!reset_n) (|req_ready) |-> !busy);
    a_e_driven:     assert property (@(posedge clk) disable iff (!reset_n) lcd_e |-> lcd_data_oe);
    a_rw_low:       assert property (@(posedge clk) lcd_rw == 1'b0);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: directed scenarios plus random traffic,
// all judged against a transaction-level timing model of the bus.
module tb_lcd_bus_sequencer;

    localparam int NREQ   = 2;
    localparam int T_AS   = 2;
    localparam int T_PW   = 12;
    localparam int T_H    = 2;
    localparam int T_CMD  = 40;
    localparam int T_LONG = 300;
    localparam int CW     = 17;
    localparam int BASE   = 1 + T_AS + T_PW + T_H;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_rs = '0;
    logic [NREQ-1:0][7:0] req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 lcd_rs;
    logic                 lcd_rw;
    logic                 lcd_e;
    logic [7:0]           lcd_data_out;
    logic                 lcd_data_oe;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: last accepted transaction and the cycle the bus frees up.
    int         idle_at  = 0;
    int         acc_cyc  = -100000;
    logic       m_rs     = 1'b0;
    logic [7:0] m_data   = '0;

    lcd_bus_sequencer #(
        .NREQ   (NREQ),
        .T_AS   (T_AS),
        .T_PW   (T_PW),
        .T_H    (T_H),
        .T_CMD  (T_CMD),
        .T_LONG (T_LONG),
        .CW     (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_rs       (req_rs),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] lowest(input logic [NREQ-1:0] v);
        return v & (~v + NREQ'(1));
    endfunction

    // Predicts every output for the current cycle, then books an acceptance if one happens.
    task automatic model_check();
        logic [NREQ-1:0] e_ready;
        logic            idle;
        logic            e_e;
        logic            e_oe;
        int              dur;
        idle    = (cyc >= idle_at);
        e_ready = idle ? lowest(req_valid) : '0;
        e_e     = (cyc >= acc_cyc + T_AS + 1) && (cyc <= acc_cyc + T_AS + T_PW);
        e_oe    = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + T_AS + T_PW + T_H);
        check("bus", {req_ready, lcd_e, lcd_rs, lcd_rw, lcd_data_out, lcd_data_oe, busy},
                     {e_ready, e_e, m_rs, 1'b0, m_data, e_oe, !idle});
        for (int i = 0; i < NREQ; i++) begin
            if (e_ready[i]) begin
                acc_cyc = cyc;
                m_rs    = req_rs[i];
                m_data  = req_data[i];
                dur     = (m_rs == 1'b0 && m_data < 8'h04) ? T_LONG : T_CMD;
                idle_at = cyc + BASE + dur;
            end
        end
    endtask

    // One clock cycle: check at the falling edge, return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_e", lcd_e, 1'b0);
        check("rst_oe", lcd_data_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rs_data", {lcd_rs, lcd_data_out}, 9'h000);
        check("rst_rw_ready", {lcd_rw, req_ready}, '0);
        req_valid = '0;
        req_rs    = '0;
        req_data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = cyc + 2;
        idle_at = cyc;
        acc_cyc = -100000;
        m_rs    = 1'b0;
        m_data  = '0;
    endtask

    // A lone write from an idle bus, with the strobe edges and the idle return pinned down.
    task automatic single(input int idx, input logic rs, input logic [7:0] d, input int dur);
        int c0;
        c0 = cyc;
        req_valid[idx] = 1'b1;
        req_rs[idx]    = rs;
        req_data[idx]  = d;
        #1;
        check("sw_ready", req_ready, NREQ'(1) << idx);
        tick();
        req_valid = '0;
        req_data  = '0;
        req_rs    = '0;
        #1;
        check("sw_latch", {lcd_data_oe, lcd_rs, lcd_data_out}, {1'b1, rs, d});
        run_to(c0 + T_AS);
        check("sw_e_before", lcd_e, 1'b0);
        run_to(c0 + T_AS + 1);
        check("sw_e_rise", lcd_e, 1'b1);
        run_to(c0 + T_AS + T_PW);
        check("sw_e_last", lcd_e, 1'b1);
        run_to(c0 + T_AS + T_PW + 1);
        check("sw_hold", {lcd_e, lcd_data_oe}, 2'b01);
        run_to(c0 + BASE);
        check("sw_wait", {lcd_data_oe, busy}, 2'b01);
        run_to(c0 + BASE + dur - 1);
        check("sw_busy_end", busy, 1'b1);
        run_to(c0 + BASE + dur);
        check("sw_idle", busy, 1'b0);
    endtask

    initial begin
        int         c0;
        logic [7:0] snap;

        do_reset();

        single(1, 1'b1, 8'h41, T_CMD);
        single(0, 1'b0, 8'h01, T_LONG);
        single(0, 1'b0, 8'h38, T_CMD);
        single(1, 1'b0, 8'h03, T_LONG);
        single(0, 1'b0, 8'h04, T_CMD);

        // Contention: index 0 wins, index 1 keeps valid and is served at the next idle.
        c0 = cyc;
        req_valid   = 2'b11;
        req_rs      = 2'b11;
        req_data[0] = 8'h55;
        req_data[1] = 8'hA5;
        #1;
        check("ct_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        run_to(c0 + BASE + T_CMD - 1);
        #1;
        check("ct_wait", req_ready, 2'b00);
        run_to(c0 + BASE + T_CMD);
        #1;
        check("ct_second", req_ready, 2'b10);
        tick();
        req_valid = '0;
        #1;
        check("ct_latch", {lcd_rs, lcd_data_out}, {1'b1, 8'hA5});
        run_to(c0 + 2 * (BASE + T_CMD));

        // Request raised mid-WAIT with data changing every cycle: the accept-cycle byte is used.
        c0 = cyc;
        req_valid = 2'b01;
        req_rs    = 2'b11;
        req_data  = {8'h00, 8'h20};
        tick();
        req_valid = '0;
        run_to(c0 + 20);
        req_valid = 2'b10;
        while (cyc < c0 + BASE + T_CMD) begin
            req_data[1] = 8'(cyc);
            tick();
        end
        req_data[1] = 8'(cyc);
        snap = req_data[1];
        #1;
        check("wt_accept", req_ready, 2'b10);
        tick();
        req_valid   = '0;
        req_data[1] = ~snap;
        #1;
        check("wt_latch", lcd_data_out, snap);
        run_to(c0 + 2 * (BASE + T_CMD));

        // Reset while E is high: the strobe drops at once and the byte is dropped for good.
        c0 = cyc;
        req_valid   = 2'b10;
        req_rs      = 2'b10;
        req_data[1] = 8'h77;
        tick();
        req_valid = '0;
        run_to(c0 + 8);
        check("mp_e_high", lcd_e, 1'b1);
        do_reset();
        c0 = cyc;
        req_valid   = 2'b01;
        req_rs      = 2'b00;
        req_data[0] = 8'h30;
        #1;
        check("mp_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1;
        check("mp_restart", {busy, lcd_data_oe, lcd_data_out}, {2'b11, 8'h30});
        run_to(c0 + BASE + T_CMD);

        // Withdrawn request: valid pulses while busy and is gone before the bus frees up.
        c0 = cyc;
        req_valid   = 2'b10;
        req_rs      = 2'b10;
        req_data[1] = 8'h5A;
        tick();
        req_valid = '0;
        run_to(c0 + 5);
        req_valid = 2'b01;
        run_to(c0 + 8);
        req_valid = '0;
        run_to(c0 + BASE + T_CMD + 10);
        check("wd_quiet", {busy, lcd_e, lcd_data_oe}, 3'b000);

        // Random traffic with frequent clear/home commands and contention.
        for (int n = 0; n < 6000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    req_rs[i]   = 1'b0;
                    req_data[i] = 8'($urandom_range(0, 3));
                end else begin
                    req_rs[i]   = 1'($urandom_range(0, 1));
                    req_data[i] = 8'($urandom);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
